// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-file slice: default widths, the
// hard-wired zero register address and a flat-bus field extractor.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Returns field idx of a flat bus packed at the given width; callers
    // truncate to their own width (fields up to 32 bits, buses up to 256).
    function automatic logic [31:0] bus_field(input logic [255:0] bus,
                                              input int idx,
                                              input int width);
        return 32'(bus >> (idx * width));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an exact,
// incrementally maintained count of busy registers.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic                   clr0_en,
    input  logic [ADDR_W-1:0]      clr0_addr,
    input  logic                   clr1_en,
    input  logic [ADDR_W-1:0]      clr1_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic              iss_set;
    logic              inc;
    logic              dec0;
    logic              dec1;
    logic [DEPTH-1:0]  busy_nxt;

    always_comb begin
        iss_set = iss_en && !((ZERO_R0 != 0) && (iss_addr == ADDR_W'(REG_ZERO)));

        busy_nxt = busy;
        if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
        if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
        if (iss_set) busy_nxt[iss_addr]  = 1'b1;

        // An issue landing on a cleared register re-arms it, so that clear
        // does not count; a duplicate clear from port 1 counts only once.
        inc  = iss_set && !busy[iss_addr];
        dec0 = clr0_en && busy[clr0_addr] && !(iss_set && (iss_addr == clr0_addr));
        dec1 = clr1_en && busy[clr1_addr] && !(iss_set && (iss_addr == clr1_addr))
               && !(clr0_en && (clr0_addr == clr1_addr));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= pend_cnt + CW'(inc) - CW'(dec0) - CW'(dec1);
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port CPU register file: NUM_RD combinational read ports, two write
// ports (port 1 wins collisions), optional bypass and zero register.
module reg_file_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              keep0;
    logic              keep1;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bz;

    assign keep0 = we0 && !((ZERO_R0 != 0) && (wa0 == ZERO_ADDR));
    assign keep1 = we1 && !((ZERO_R0 != 0) && (wa1 == ZERO_ADDR));

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .clr0_en   (we0),
        .clr0_addr (wa0),
        .clr1_en   (we1),
        .clr1_addr (wa1),
        .busy      (busy),
        .pend_cnt  (pend_cnt)
    );

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (keep0) regs[wa0] <= wd0;
            if (keep1) regs[wa1] <= wd1;
        end
    end

    // Overrides are applied lowest priority first.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        rd    = '0;
        bz    = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = ADDR_W'(bus_field(256'(raddr), i, ADDR_W));
            rd = regs[ra];
            bz = busy[ra];
            if ((BYPASS != 0) && reset && we0 && (wa0 == ra)) begin
                rd = wd0;
                bz = 1'b0;
            end
            if ((BYPASS != 0) && reset && we1 && (wa1 == ra)) begin
                rd = wd1;
                bz = 1'b0;
            end
            if ((ZERO_R0 != 0) && (ra == ZERO_ADDR)) begin
                rd = '0;
                bz = 1'b0;
            end
            rdata[i*DATA_W +: DATA_W] = rd;
            rbusy[i]                  = bz;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; three instances share stimulus: defaults,
// no-bypass, and no-zero-register.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic        we0, we1, iss_en;
    logic [4:0]  wa0, wa1, iss_addr;
    logic [31:0] wd0, wd1;

    logic [63:0] rdata_a, rdata_b, rdata_z;
    logic [1:0]  rbusy_a, rbusy_b, rbusy_z;
    logic [5:0]  pend_a, pend_b, pend_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_a)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_b)
    );

    reg_file_mp #(.ZERO_R0(0)) dut_nz (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_z), .rbusy(rbusy_z),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_z)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234_5678;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h8765_4321;
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        idle();
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        idle();
        reset = 1'b0;
        step();
        step();
        raddr = {5'd7, 5'd3};
        #1;
        checks++;
        if (rdata_a !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected %h", rdata_a, 64'h0);
        end
        checks++;
        if (rbusy_a !== 2'b00) begin
            errors++; $display("FAIL reset_rbusy: got %b expected %b", rbusy_a, 2'b00);
        end
        checks++;
        if (pend_a !== 6'd0) begin
            errors++; $display("FAIL reset_pend: got %0d expected %0d", pend_a, 0);
        end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFE_F00D;
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h0) begin
            errors++; $display("FAIL reset_bypass_gated: got %h expected %h", rdata_a[31:0], 32'h0);
        end
        step();
        idle();
        reset = 1'b1;
        step();
        checks++;
        if (rdata_a[31:0] !== 32'h0) begin
            errors++; $display("FAIL reset_write_ignored: got %h expected %h", rdata_a[31:0], 32'h0);
        end
    endtask

    task automatic test_write_ports();
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h0000_F00F;
        step();
        idle();
        raddr = {5'd2, 5'd1};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL write_p0: got %h expected %h", rdata_a[31:0], 32'hFFFF_FFFF);
        end
        checks++;
        if (rdata_a[63:32] !== 32'h0000_F00F) begin
            errors++; $display("FAIL write_p1: got %h expected %h", rdata_a[63:32], 32'h0000_F00F);
        end
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hAA00_00AA;
        step();
        idle();
        raddr = {5'd2, 5'd4};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'hAA00_00AA) begin
            errors++; $display("FAIL write_collision: got %h expected %h", rdata_a[31:0], 32'hAA00_00AA);
        end
        checks++;
        if (rdata_b[31:0] !== 32'hAA00_00AA) begin
            errors++; $display("FAIL write_collision_nb: got %h expected %h", rdata_b[31:0], 32'hAA00_00AA);
        end
    endtask

    task automatic test_bypass();
        raddr = {5'd2, 5'd5};
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hFF00_FF00;
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'hFF00_FF00) begin
            errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rdata_a[31:0], 32'hFF00_FF00);
        end
        checks++;
        if (rdata_b[31:0] !== 32'h0) begin
            errors++; $display("FAIL nobypass_old: got %h expected %h", rdata_b[31:0], 32'h0);
        end
        step();
        idle();
        #1;
        checks++;
        if (rdata_b[31:0] !== 32'hFF00_FF00) begin
            errors++; $display("FAIL nobypass_next: got %h expected %h", rdata_b[31:0], 32'hFF00_FF00);
        end
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h0BAD_0BAD;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1357_9BDF;
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h0BAD_0BAD) begin
            errors++; $display("FAIL bypass_p1_priority: got %h expected %h", rdata_a[31:0], 32'h0BAD_0BAD);
        end
        step();
        idle();
    endtask

    task automatic test_zero_reg();
        raddr = {5'd2, 5'd0};
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h0) begin
            errors++; $display("FAIL zero_bypass: got %h expected %h", rdata_a[31:0], 32'h0);
        end
        step();
        idle();
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h0) begin
            errors++; $display("FAIL zero_read: got %h expected %h", rdata_a[31:0], 32'h0);
        end
        checks++;
        if (rbusy_a[0] !== 1'b0) begin
            errors++; $display("FAIL zero_rbusy: got %b expected %b", rbusy_a[0], 1'b0);
        end
        checks++;
        if (pend_a !== 6'd0) begin
            errors++; $display("FAIL zero_pend: got %0d expected %0d", pend_a, 0);
        end
        checks++;
        if (rdata_z[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL nz_r0_data: got %h expected %h", rdata_z[31:0], 32'hDEAD_BEEF);
        end
        checks++;
        if (pend_z !== 6'd1 || rbusy_z[0] !== 1'b1) begin
            errors++; $display("FAIL nz_r0_busy: got pend=%0d busy=%b expected pend=1 busy=1", pend_z, rbusy_z[0]);
        end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        checks++;
        if (pend_a !== 6'd1) begin
            errors++; $display("FAIL sb_issue3: got %0d expected %0d", pend_a, 1);
        end
        iss_addr = 5'd9;
        step();
        checks++;
        if (pend_a !== 6'd2) begin
            errors++; $display("FAIL sb_issue9: got %0d expected %0d", pend_a, 2);
        end
        iss_addr = 5'd3;
        step();
        checks++;
        if (pend_a !== 6'd2) begin
            errors++; $display("FAIL sb_reissue3: got %0d expected %0d", pend_a, 2);
        end
        iss_addr = 5'd9;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0009;
        step();
        idle();
        raddr = {5'd9, 5'd0};
        #1;
        checks++;
        if (rbusy_a[1] !== 1'b1 || pend_a !== 6'd2) begin
            errors++; $display("FAIL sb_issue_wins: got busy=%b pend=%0d expected busy=1 pend=2", rbusy_a[1], pend_a);
        end
        raddr = {5'd3, 5'd0};
        #1;
        checks++;
        if (rbusy_a[1] !== 1'b1) begin
            errors++; $display("FAIL sb_busy3: got %b expected %b", rbusy_a[1], 1'b1);
        end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0003;
        #1;
        checks++;
        if (rbusy_a[1] !== 1'b0) begin
            errors++; $display("FAIL sb_bypass_rbusy: got %b expected %b", rbusy_a[1], 1'b0);
        end
        checks++;
        if (rbusy_b[1] !== 1'b1) begin
            errors++; $display("FAIL sb_nobypass_rbusy: got %b expected %b", rbusy_b[1], 1'b1);
        end
        step();
        idle();
        checks++;
        if (pend_a !== 6'd1) begin
            errors++; $display("FAIL sb_clear3: got %0d expected %0d", pend_a, 1);
        end
    endtask

    task automatic test_full_count();
        for (int a = 0; a < 32; a++) begin
            iss_en = 1'b1; iss_addr = 5'(a);
            step();
        end
        idle();
        checks++;
        if (pend_z !== 6'd32) begin
            errors++; $display("FAIL full_nz: got %0d expected %0d", pend_z, 32);
        end
        checks++;
        if (pend_a !== 6'd31) begin
            errors++; $display("FAIL full_zero_r0: got %0d expected %0d", pend_a, 31);
        end
    endtask

    task automatic test_back_to_back();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h5;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h6;
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        checks++;
        if (pend_z !== 6'd30) begin
            errors++; $display("FAIL b2b_two_clears: got %0d expected %0d", pend_z, 30);
        end
        iss_en = 1'b0;
        wa0 = 5'd8; wa1 = 5'd8;
        step();
        idle();
        checks++;
        if (pend_z !== 6'd29 || pend_a !== 6'd28) begin
            errors++; $display("FAIL b2b_same_clear: got nz=%0d a=%0d expected nz=29 a=28", pend_z, pend_a);
        end
        reset = 1'b0;
        iss_en = 1'b1; iss_addr = 5'd12;
        step();
        idle();
        reset = 1'b1;
        raddr = {5'd9, 5'd0};
        #1;
        checks++;
        if (pend_z !== 6'd0 || pend_a !== 6'd0) begin
            errors++; $display("FAIL b2b_reset_pend: got nz=%0d a=%0d expected 0", pend_z, pend_a);
        end
        checks++;
        if (rbusy_z !== 2'b00) begin
            errors++; $display("FAIL b2b_reset_rbusy: got %b expected %b", rbusy_z, 2'b00);
        end
    endtask

    initial begin
        reset = 1'b0;
        raddr = '0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_en = 1'b0; iss_addr = '0;
        step();
        test_reset();
        test_write_ports();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_full_count();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file, successor to the single-write, two-read CPU register file.
- Adds a configurable read-port count, a second write port, optional write-to-read bypass, optional hard-wired zero register, and a pending-write scoreboard with a busy counter.
- Sits in the CPU decode stage: reads operands, takes write-back from two sources, and flags operands whose producers have not yet written back.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
- ZERO_R0, 1, 1 = register 0 reads as 0, ignores writes, and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  1 = the register addressed by port i has a write pending.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- iss_en  in  1  issue strobe; marks iss_addr as pending.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- pend_cnt  out  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset: while reset==0 at a rising edge, all registers are cleared to 0, all busy bits to 0, and pend_cnt to 0. Writes and issues in that cycle are ignored.
- While reset==0, bypass is suppressed, so rdata reflects register contents only (all 0 after the first reset edge). rbusy is 0 after the first reset edge.
- Reset asserted in the middle of activity discards pending busy state and in-flight writes, with no partial update.
- Write: on a rising edge with reset==1, for each port with we asserted, reg[wa] <= wd.
- Write collision: if wa0==wa1 with both enables high, port 1 wins.
- ZERO_R0=1: writes to address 0 are dropped.
- Read: combinational, zero latency. rdata_i = reg[raddr_i], with these overrides in priority order:
  - ZERO_R0 and raddr_i==0 -> 0.
  - BYPASS, reset==1, we1 and wa1==raddr_i -> wd1.
  - BYPASS, reset==1, we0 and wa0==raddr_i -> wd0.
- BYPASS=0: a write becomes visible on reads in the cycle after its edge.
- Scoreboard: one busy bit per register.
  - iss_en sets busy[iss_addr].
  - A write on either port clears busy[wa].
  - Issue and write to the same address in the same cycle: the issue wins and busy ends at 1 (a new producer).
  - Issue to an already-busy register leaves it busy; the count is not double-counted.
  - ZERO_R0=1: address 0 is never set.
- rbusy_i = busy[raddr_i], forced to 0 when any of these holds:
  - ZERO_R0 and raddr_i==0;
  - BYPASS and a same-cycle write targets raddr_i.
- pend_cnt: registered. It equals the popcount of the busy vector after each edge, and is updated incrementally (+1 on a new set, -1 per distinct cleared busy register, net per cycle).
  - Range is 0..2**ADDR_W. It never wraps, because the count is exact by construction.
- State: no FSM beyond the scoreboard. All outputs are fully determined by the register array, the busy vector, pend_cnt and the current inputs.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W defaults;
  - the REG_ZERO address constant;
  - a function for flat-bus slice extraction.
- One natural sub-module: reg_scoreboard.
  - Holds the busy vector and pend_cnt.
  - Inputs: issue, the two write-clears and reset.
  - Output: busy vector.
- reg_file_mp holds the storage array, write arbitration, and the read/bypass muxes.

Test Plan:
1. Reset low for 2 edges after random writes -> raddr={3,7} gives rdata=0, rbusy=0, pend_cnt=0. With reset low, we0=1, wa0=3 and no edge yet -> rdata for port 0 stays 0 (bypass gated).
2. we0=1, wa0=1, wd0=FFFFFFFF and we1=1, wa1=2, wd1=0000F00F in one cycle -> next cycle raddr={1,2} reads FFFFFFFF, 0000F00F. Then we0=we1=1, wa0=wa1=4, wd0=11111111, wd1=AA0000AA -> reg4=AA0000AA.
3. BYPASS=1: raddr0=5, we0=1, wa0=5, wd0=FF00FF00 -> rdata port 0 = FF00FF00 in the same cycle. Rerun with BYPASS=0 -> old value 0 in that cycle, FF00FF00 the next.
4. ZERO_R0=1: we0=1, wa0=0, wd0=DEADBEEF, iss_en=1, iss_addr=0 -> raddr=0 reads 0, rbusy=0, pend_cnt=0.
5. Issue r3, then r9, then r3 again -> pend_cnt 1, 2, 2. Then iss_en=1, iss_addr=9 with we1=1, wa1=9 in the same cycle -> busy9 stays 1, pend_cnt=2. Then we0=1, wa0=3 with raddr1=3 -> rbusy1=0 in the same cycle (BYPASS=1), pend_cnt=1 next.
6. Set busy on 32 registers with ZERO_R0=0 -> pend_cnt=32 (6-bit, no wrap). Then drop reset for one edge -> pend_cnt=0 and all rbusy=0.
